// File: rtl/stream_loader_fsm.sv
// Host-stream loader: decodes framed words from a FWFT FIFO into instruction/weight/XY
// memory writes, and hands RUN frames to the controller through a start/done handshake.
module stream_loader_fsm #(
  parameter int DATA_WIDTH     = 32,
  parameter int NU_COUNT       = 4,
  parameter int INST_MEM_DEPTH = 8,
  parameter int W_MEM_DEPTH    = 10,
  parameter int XY_MEM_DEPTH   = 10,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_buffer_empty,
  input  logic [DATA_WIDTH-1:0]     i_buffer_data,
  output logic                      o_buffer_read_enable,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic                      o_inst_write_enable,
  output logic [INST_MEM_DEPTH-1:0] o_inst_write_addr,
  output logic [NU_COUNT-1:0]       o_w_write_enable,
  output logic [W_MEM_DEPTH-1:0]    o_w_write_addr,
  output logic                      o_xy_write_enable,
  output logic [XY_MEM_DEPTH:0]     o_xy_write_addr,
  output logic                      o_ctrl_start,
  input  logic                      i_ctrl_done,
  output logic                      o_busy,
  output logic                      o_error
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
    S_RUN,
    S_RUN_WAIT
  } state_t;

  localparam logic [1:0] TGT_INST = 2'b00;
  localparam logic [1:0] TGT_W    = 2'b01;
  localparam logic [1:0] TGT_XY   = 2'b10;
  localparam logic [1:0] TGT_RUN  = 2'b11;
  localparam logic [5:0] BANK_ALL = 6'h3F;

  localparam int XY_AW  = XY_MEM_DEPTH + 1;
  localparam int AW_IW  = (INST_MEM_DEPTH > W_MEM_DEPTH) ? INST_MEM_DEPTH : W_MEM_DEPTH;
  localparam int AW     = (AW_IW > XY_AW) ? AW_IW : XY_AW;

  localparam logic [AW-1:0] INST_MASK = AW'((64'd1 << INST_MEM_DEPTH) - 64'd1);
  localparam logic [AW-1:0] W_MASK    = AW'((64'd1 << W_MEM_DEPTH) - 64'd1);
  localparam logic [AW-1:0] XY_MASK   = AW'((64'd1 << XY_AW) - 64'd1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [1:0]                r_target;
  logic [5:0]                r_bank;
  logic [LEN_WIDTH-1:0]      r_remaining;
  logic [AW-1:0]             r_addr;
  logic                      r_error;

  logic [DATA_WIDTH-1:0]     r_write_data;
  logic                      r_inst_we;
  logic [INST_MEM_DEPTH-1:0] r_inst_addr;
  logic [NU_COUNT-1:0]       r_w_we;
  logic [W_MEM_DEPTH-1:0]    r_w_addr;
  logic                      r_xy_we;
  logic [XY_MEM_DEPTH:0]     r_xy_addr;

  logic                      w_pop;
  logic                      w_ctrl_start;
  logic                      w_busy;
  logic [1:0]                w_hdr_target;
  logic [5:0]                w_hdr_bank;
  logic                      w_hdr_bad_bank;
  logic [NU_COUNT-1:0]       w_bank_mask;
  logic [AW-1:0]             w_addr_mask;

  assign w_hdr_target   = i_buffer_data[31:30];
  assign w_hdr_bank     = i_buffer_data[29:24];
  assign w_hdr_bad_bank = (w_hdr_bank != BANK_ALL) && (int'(w_hdr_bank) >= NU_COUNT);

  // Bank 63 broadcasts to every weight bank; out-of-range banks select none.
  always_comb begin
    w_bank_mask = '0;
    for (int i = 0; i < NU_COUNT; i++) begin
      if ((r_bank == BANK_ALL) || (int'(r_bank) == i)) begin
        w_bank_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr_mask = INST_MASK;
    case (r_target)
      TGT_W:   w_addr_mask = W_MASK;
      TGT_XY:  w_addr_mask = XY_MASK;
      default: w_addr_mask = INST_MASK;
    endcase
  end

  // Pops are gated by the reset input so nothing is consumed while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_ctrl_start = 1'b0;
    w_busy       = (r_state != S_HDR0);
    case (r_state)
      S_HDR0: begin
        w_pop = i_reset && !i_buffer_empty;
        if (w_pop) begin
          w_next_state = (w_hdr_target == TGT_RUN) ? S_RUN : S_HDR1;
        end
      end
      S_HDR1: begin
        w_pop = i_reset && !i_buffer_empty;
        if (w_pop) begin
          w_next_state = (r_remaining == '0) ? S_HDR0 : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_pop = i_reset && !i_buffer_empty;
        if (w_pop && (r_remaining == LEN_WIDTH'(1))) begin
          w_next_state = S_HDR0;
        end
      end
      S_RUN: begin
        w_ctrl_start = 1'b1;
        w_next_state = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (i_ctrl_done) begin
          w_next_state = S_HDR0;
        end
      end
      default: w_next_state = S_HDR0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Header decode, address counter and the registered write port.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_target     <= TGT_INST;
      r_bank       <= '0;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_error      <= 1'b0;
      r_write_data <= '0;
      r_inst_we    <= 1'b0;
      r_inst_addr  <= '0;
      r_w_we       <= '0;
      r_w_addr     <= '0;
      r_xy_we      <= 1'b0;
      r_xy_addr    <= '0;
    end else begin
      r_inst_we <= 1'b0;
      r_w_we    <= '0;
      r_xy_we   <= 1'b0;
      if (w_pop) begin
        case (r_state)
          S_HDR0: begin
            r_target    <= w_hdr_target;
            r_bank      <= w_hdr_bank;
            r_remaining <= i_buffer_data[LEN_WIDTH-1:0];
            if ((w_hdr_target == TGT_W) && w_hdr_bad_bank) begin
              r_error <= 1'b1;
            end
          end
          S_HDR1: begin
            r_addr <= i_buffer_data[AW-1:0] & w_addr_mask;
          end
          S_PAYLOAD: begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            r_addr      <= (r_addr + AW'(1)) & w_addr_mask;
            case (r_target)
              TGT_INST: begin
                r_inst_we    <= 1'b1;
                r_inst_addr  <= r_addr[INST_MEM_DEPTH-1:0];
                r_write_data <= i_buffer_data;
              end
              TGT_W: begin
                if (w_bank_mask != '0) begin
                  r_w_we       <= w_bank_mask;
                  r_w_addr     <= r_addr[W_MEM_DEPTH-1:0];
                  r_write_data <= i_buffer_data;
                end
              end
              TGT_XY: begin
                r_xy_we      <= 1'b1;
                r_xy_addr    <= r_addr[XY_MEM_DEPTH:0];
                r_write_data <= i_buffer_data;
              end
              default: begin
              end
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_buffer_read_enable = w_pop;
  assign o_ctrl_start         = w_ctrl_start;
  assign o_busy               = w_busy;
  assign o_error              = r_error;
  assign o_write_data         = r_write_data;
  assign o_inst_write_enable  = r_inst_we;
  assign o_inst_write_addr    = r_inst_addr;
  assign o_w_write_enable     = r_w_we;
  assign o_w_write_addr       = r_w_addr;
  assign o_xy_write_enable    = r_xy_we;
  assign o_xy_write_addr      = r_xy_addr;

endmodule

// File: tb/tb_stream_loader_fsm.sv
// Directed bench for stream_loader_fsm: a per-cycle vector table for INST/W frames,
// then hand-written XY-stall, RUN handshake and mid-frame reset sequences.
module tb_stream_loader_fsm;

  typedef struct {
    logic        empty;
    logic [31:0] data;
    logic        done;
    logic        rd;
    logic        start;
    logic        busy;
    logic        err;
    logic        iwe;
    logic [7:0]  iaddr;
    logic [3:0]  wwe;
    logic [9:0]  waddr;
    logic        xwe;
    logic [10:0] xaddr;
    logic [31:0] wdata;
  } vec_t;

  localparam logic [31:0] D0 = 32'hA0A0_0001, D1 = 32'hA0A0_0002, D2 = 32'hA0A0_0003;
  localparam logic [31:0] E0 = 32'hB0B0_0001, E1 = 32'hB0B0_0002;
  localparam logic [31:0] F0 = 32'hDEAD_0001, F1 = 32'hDEAD_0002;
  localparam logic [31:0] G0 = 32'h600D_0002;
  localparam logic [31:0] X0 = 32'hC0DE_0000, X1 = 32'hC0DE_0001;
  localparam logic [31:0] X2 = 32'hC0DE_0002, X3 = 32'hC0DE_0003;
  localparam logic [31:0] P0 = 32'h1111_0000, P1 = 32'h1111_0001, P2 = 32'h1111_0002;
  localparam logic [31:0] Z0 = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        resetN;
  logic        bufEmpty;
  logic [31:0] bufData;
  logic        readEn;
  logic [31:0] writeData;
  logic        instWe;
  logic [7:0]  instAddr;
  logic [3:0]  wWe;
  logic [9:0]  wAddr;
  logic        xyWe;
  logic [10:0] xyAddr;
  logic        ctrlStart;
  logic        ctrlDone;
  logic        busy;
  logic        errFlag;

  int checks = 0;
  int errors = 0;
  int xyWrites = 0;
  int instWrites = 0;
  int startPulses = 0;
  vec_t e;
  vec_t tbl [19];

  stream_loader_fsm dut (
    .i_clk                (clk),
    .i_reset              (resetN),
    .i_buffer_empty       (bufEmpty),
    .i_buffer_data        (bufData),
    .o_buffer_read_enable (readEn),
    .o_write_data         (writeData),
    .o_inst_write_enable  (instWe),
    .o_inst_write_addr    (instAddr),
    .o_w_write_enable     (wWe),
    .o_w_write_addr       (wAddr),
    .o_xy_write_enable    (xyWe),
    .o_xy_write_addr      (xyAddr),
    .o_ctrl_start         (ctrlStart),
    .i_ctrl_done          (ctrlDone),
    .o_busy               (busy),
    .o_error              (errFlag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (xyWe) xyWrites++;
    if (instWe) instWrites++;
    if (ctrlStart) startPulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic emp, input logic [31:0] dat, input logic dn);
    @(negedge clk);
    bufEmpty = emp;
    bufData  = dat;
    ctrlDone = dn;
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t x);
    chk({tag, ".rd"},    32'(readEn),    32'(x.rd));
    chk({tag, ".start"}, 32'(ctrlStart), 32'(x.start));
    chk({tag, ".busy"},  32'(busy),      32'(x.busy));
    chk({tag, ".err"},   32'(errFlag),   32'(x.err));
    chk({tag, ".iwe"},   32'(instWe),    32'(x.iwe));
    chk({tag, ".iaddr"}, 32'(instAddr),  32'(x.iaddr));
    chk({tag, ".wwe"},   32'(wWe),       32'(x.wwe));
    chk({tag, ".waddr"}, 32'(wAddr),     32'(x.waddr));
    chk({tag, ".xwe"},   32'(xyWe),      32'(x.xwe));
    chk({tag, ".xaddr"}, 32'(xyAddr),    32'(x.xaddr));
    chk({tag, ".wdata"}, writeData,      x.wdata);
  endtask

  task automatic step(input string tag, input logic emp, input logic [31:0] dat, input logic dn);
    applyStimulus(emp, dat, dn);
    checkOutput(tag, e);
  endtask

  initial begin
    int snap;
    // empty,data,done | rd,start,busy,err,iwe,iaddr,wwe,waddr,xwe,xaddr,wdata
    tbl[0]  = '{0, 32'h0000_0003, 0, 1, 0, 0, 0, 0, 8'h00, 4'h0, 10'h000, 0, 11'h000, 32'h0};
    tbl[1]  = '{0, 32'h0000_0005, 0, 1, 0, 1, 0, 0, 8'h00, 4'h0, 10'h000, 0, 11'h000, 32'h0};
    tbl[2]  = '{0, D0,            0, 1, 0, 1, 0, 0, 8'h00, 4'h0, 10'h000, 0, 11'h000, 32'h0};
    tbl[3]  = '{0, D1,            0, 1, 0, 1, 0, 1, 8'h05, 4'h0, 10'h000, 0, 11'h000, D0};
    tbl[4]  = '{0, D2,            0, 1, 0, 1, 0, 1, 8'h06, 4'h0, 10'h000, 0, 11'h000, D1};
    tbl[5]  = '{1, 32'h0,         0, 0, 0, 0, 0, 1, 8'h07, 4'h0, 10'h000, 0, 11'h000, D2};
    tbl[6]  = '{1, 32'h0,         0, 0, 0, 0, 0, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, D2};
    tbl[7]  = '{0, 32'h7F00_0002, 0, 1, 0, 0, 0, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, D2};
    tbl[8]  = '{0, 32'h0000_03FF, 0, 1, 0, 1, 0, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, D2};
    tbl[9]  = '{0, E0,            0, 1, 0, 1, 0, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, D2};
    tbl[10] = '{0, E1,            0, 1, 0, 1, 0, 0, 8'h07, 4'hF, 10'h3FF, 0, 11'h000, E0};
    tbl[11] = '{0, 32'h4700_0002, 0, 1, 0, 0, 0, 0, 8'h07, 4'hF, 10'h000, 0, 11'h000, E1};
    tbl[12] = '{0, 32'h0000_0010, 0, 1, 0, 1, 1, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, E1};
    tbl[13] = '{0, F0,            0, 1, 0, 1, 1, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, E1};
    tbl[14] = '{0, F1,            0, 1, 0, 1, 1, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, E1};
    tbl[15] = '{0, 32'h4200_0001, 0, 1, 0, 0, 1, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, E1};
    tbl[16] = '{0, 32'h0000_0020, 0, 1, 0, 1, 1, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, E1};
    tbl[17] = '{0, G0,            0, 1, 0, 1, 1, 0, 8'h07, 4'h0, 10'h000, 0, 11'h000, E1};
    tbl[18] = '{1, 32'h0,         0, 0, 0, 0, 1, 0, 8'h07, 4'h4, 10'h020, 0, 11'h000, G0};

    resetN   = 1'b0;
    bufEmpty = 1'b0;
    bufData  = 32'h0000_0003;
    ctrlDone = 1'b0;
    e = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 10'h000, 0, 11'h000, 32'h0};
    #2;
    checkOutput("reset", e);
    @(negedge clk);
    bufEmpty = 1'b1;
    @(negedge clk);
    resetN = 1'b1;

    // INST frame, W broadcast with wrap, bad bank, then a valid single-bank frame.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].empty, tbl[i].data, tbl[i].done);
      checkOutput($sformatf("vec%0d", i), tbl[i]);
    end

    // XY frame with a three-cycle FIFO stall between words 2 and 3; 11-bit address wrap.
    e = tbl[18];
    e.wwe = 4'h0;
    snap = xyWrites;
    e.rd = 1; e.busy = 0; step("xy.hdr0", 0, 32'h8000_0004, 0);
    e.busy = 1;           step("xy.hdr1", 0, 32'h0000_07FE, 0);
                          step("xy.w0", 0, X0, 0);
    e.xwe = 1; e.xaddr = 11'h7FE; e.wdata = X0; step("xy.w1", 0, X1, 0);
    e.xaddr = 11'h7FF; e.wdata = X1; step("xy.w2", 0, X2, 0);
    e.rd = 0; e.xaddr = 11'h000; e.wdata = X2; step("xy.stall0", 1, 32'h0, 0);
    e.xwe = 0;            step("xy.stall1", 1, 32'h0, 0);
                          step("xy.stall2", 1, 32'h0, 0);
    e.rd = 1;             step("xy.w3", 0, X3, 0);
    e.rd = 0; e.busy = 0; e.xwe = 1; e.xaddr = 11'h001; e.wdata = X3;
    step("xy.tail", 1, 32'h0, 0);
    chk("xy.writes", 32'(xyWrites - snap), 32'd4);
    e.xwe = 0;

    // RUN: single start pulse, done in the start cycle ignored, no pops while waiting.
    snap = startPulses;
    e.rd = 1; e.busy = 0; step("run.hdr0", 0, 32'hC000_0000, 0);
    e.rd = 0; e.busy = 1; e.start = 1; step("run.start", 0, 32'h0000_0000, 1);
    e.start = 0;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("run.wait%0d", i), 0, 32'h0000_0000, (i == 9));
    end
    e.rd = 1; e.busy = 0; step("run.next", 0, 32'h0000_0000, 0);
    e.busy = 1;           step("run.len0hdr1", 0, 32'h0000_0000, 0);
    e.rd = 0; e.busy = 0; step("run.idle", 1, 32'h0, 0);
    chk("run.pulses", 32'(startPulses - snap), 32'd1);

    // Reset in the middle of a 5-word INST payload, then length-0 and 1-word frames.
    e.rd = 1; e.busy = 0; step("rst.hdr0", 0, 32'h0000_0005, 0);
    e.busy = 1;           step("rst.hdr1", 0, 32'h0000_0010, 0);
                          step("rst.p0", 0, P0, 0);
    e.iwe = 1; e.iaddr = 8'h10; e.wdata = P0; step("rst.p1", 0, P1, 0);
    e.iaddr = 8'h11; e.wdata = P1; step("rst.p2", 0, P2, 0);
    #1 resetN = 1'b0;
    #1;
    e = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 10'h000, 0, 11'h000, 32'h0};
    checkOutput("rst.active", e);
    @(negedge clk);
    checkOutput("rst.held", e);
    bufEmpty = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    snap = instWrites;
    e.rd = 1;             step("len0.hdr0", 0, 32'h0000_0000, 0);
    e.busy = 1;           step("len0.hdr1", 0, 32'h0000_0033, 0);
    e.rd = 0; e.busy = 0; step("len0.idle", 1, 32'h0, 0);
    chk("len0.writes", 32'(instWrites - snap), 32'd0);
    e.rd = 1;             step("one.hdr0", 0, 32'h0000_0001, 0);
    e.busy = 1;           step("one.hdr1", 0, 32'h0000_0002, 0);
                          step("one.w0", 0, Z0, 0);
    e.rd = 0; e.busy = 0; e.iwe = 1; e.iaddr = 8'h02; e.wdata = Z0;
    step("one.tail", 1, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
